// File: rtl/spi_slave_burst_ctrl.sv
// spi_slave_burst_ctrl: SPI slave front-end for a single-port RAM.
// MOSI is sampled once per clk while SS_n is low. Each frame carries a 2-bit
// command and then WORD_W-bit payload words:
//   00 set write address, 01 write data (burst), 10 set read address,
//   11 read data (burst) returned on MISO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   SS_n, MOSI, MISO  SPI slave pins (MISO is 0 when not shifting)
//   wr_en/wr_addr/wdata      RAM write strobe, address, data
//   rd_en/rd_addr            RAM read strobe, address
//   rdata/rdata_valid        RAM read return
//   err               sticky read-timeout flag, cleared at frame start
//   state             current FSM state (debug)
module spi_slave_burst_ctrl #(
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned BURST_EN   = 1,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rdata,
    input  logic              rdata_valid,
    output logic              err,
    output logic [2:0]        state
);

    localparam int unsigned CNT_W  = $clog2(WORD_W + 1);
    localparam int unsigned TCNT_W = $clog2(RD_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_RX_WORD  = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RDATA = 2'b11;

    logic [1:0]        cmd;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bcnt;
    logic [TCNT_W-1:0] tcnt;

    logic [2:0]        state_nxt;
    logic [1:0]        cmd_nxt;
    logic [WORD_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]  bcnt_nxt;
    logic [TCNT_W-1:0] tcnt_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [WORD_W-1:0] wdata_nxt;
    logic              wr_en_nxt;
    logic              rd_en_nxt;
    logic              miso_nxt;
    logic              err_nxt;

    logic [WORD_W-1:0] payload_c;
    logic              last_bit_c;

    // Word as it stands once the current MOSI bit is shifted in
    assign payload_c  = {shreg[WORD_W-2:0], MOSI};
    assign last_bit_c = (bcnt == CNT_W'(WORD_W - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_DONE;
            cmd     <= '0;
            shreg   <= '0;
            bcnt    <= '0;
            tcnt    <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            wdata   <= '0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            MISO    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd     <= cmd_nxt;
            shreg   <= shreg_nxt;
            bcnt    <= bcnt_nxt;
            tcnt    <= tcnt_nxt;
            wr_addr <= wr_addr_nxt;
            rd_addr <= rd_addr_nxt;
            wdata   <= wdata_nxt;
            wr_en   <= wr_en_nxt;
            rd_en   <= rd_en_nxt;
            MISO    <= miso_nxt;
            err     <= err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd;
        shreg_nxt   = shreg;
        bcnt_nxt    = bcnt;
        tcnt_nxt    = tcnt;
        wr_addr_nxt = wr_addr;
        rd_addr_nxt = rd_addr;
        wdata_nxt   = wdata;
        err_nxt     = err;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        miso_nxt    = 1'b0;

        // Burst write address steps on the edge that ends each strobe, even
        // if the frame is being aborted at the same time.
        if ((BURST_EN != 0) && wr_en) begin
            wr_addr_nxt = wr_addr + ADDR_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (!SS_n) begin
                    cmd_nxt   = {MOSI, 1'b0};
                    err_nxt   = 1'b0;
                    state_nxt = S_CMD;
                end
            end

            S_CMD: begin
                if (SS_n) begin
                    state_nxt = S_IDLE;
                end else begin
                    cmd_nxt = {cmd[1], MOSI};
                    if ({cmd[1], MOSI} == CMD_RDATA) begin
                        rd_en_nxt = 1'b1;
                        tcnt_nxt  = '0;
                        state_nxt = S_RD_WAIT;
                    end else begin
                        bcnt_nxt  = '0;
                        state_nxt = S_RX_WORD;
                    end
                end
            end

            S_RX_WORD: begin
                // A bit sampled with SS_n high is not part of the frame, so
                // even the last bit of a word is dropped on abort.
                if (SS_n) begin
                    state_nxt = S_IDLE;
                end else begin
                    shreg_nxt = payload_c;
                    bcnt_nxt  = bcnt + CNT_W'(1);
                    if (last_bit_c) begin
                        bcnt_nxt = '0;
                        case (cmd)
                            CMD_WADDR: begin
                                wr_addr_nxt = payload_c[ADDR_W-1:0];
                                state_nxt   = S_DONE;
                            end
                            CMD_RADDR: begin
                                rd_addr_nxt = payload_c[ADDR_W-1:0];
                                state_nxt   = S_DONE;
                            end
                            CMD_WDATA: begin
                                wdata_nxt = payload_c;
                                wr_en_nxt = 1'b1;
                                if (BURST_EN == 0) begin
                                    state_nxt = S_DONE;
                                end
                            end
                            default: state_nxt = S_DONE;
                        endcase
                    end
                end
            end

            S_RD_WAIT: begin
                if (SS_n) begin
                    state_nxt = S_IDLE;
                end else if (rdata_valid) begin
                    miso_nxt  = rdata[WORD_W-1];
                    shreg_nxt = {rdata[WORD_W-2:0], 1'b0};
                    bcnt_nxt  = '0;
                    state_nxt = S_RD_SHIFT;
                end else if (tcnt == TCNT_W'(RD_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end

            S_RD_SHIFT: begin
                // The last bit has already been presented, so SS_n high on
                // that edge ends the frame cleanly instead of aborting it.
                if (last_bit_c) begin
                    if ((BURST_EN != 0) && !SS_n) begin
                        rd_addr_nxt = rd_addr + ADDR_W'(1);
                        rd_en_nxt   = 1'b1;
                        tcnt_nxt    = '0;
                        state_nxt   = S_RD_WAIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else if (SS_n) begin
                    state_nxt = S_IDLE;
                end else begin
                    miso_nxt  = shreg[WORD_W-1];
                    shreg_nxt = {shreg[WORD_W-2:0], 1'b0};
                    bcnt_nxt  = bcnt + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (SS_n) begin
                    state_nxt = S_IDLE;
                end
            end

            default: state_nxt = S_DONE;
        endcase
    end

endmodule

// File: tb/tb_spi_slave_burst_ctrl.sv
// tb_spi_slave_burst_ctrl: directed bench for spi_slave_burst_ctrl with a
// one-cycle RAM read model and a write-strobe monitor.
module tb_spi_slave_burst_ctrl;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wdata;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rdata = '0;
    logic              rdata_valid = 1'b0;
    logic              err;
    logic [2:0]        state;

    logic              ram_on;
    logic [WORD_W-1:0] ram_data;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [WORD_W-1:0] wr_data_q[$];

    spi_slave_burst_ctrl #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .BURST_EN  (1),
        .RD_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (ss_n),
        .MOSI       (mosi),
        .MISO       (miso),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wdata      (wdata),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    // One-cycle RAM: data valid in the cycle after rd_en
    always @(posedge clk) begin
        rdata_valid <= rd_en && ram_on;
        rdata       <= ram_data;
    end

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wr_addr_q.push_back(wr_addr);
            wr_data_q.push_back(wdata);
        end
        if (rd_en) rd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs of the following cycle are visible
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ss_n = 1'b0;
        mosi = b;
        tick();
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        for (int i = WORD_W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle_tick();
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned rd_base;
        logic [WORD_W-1:0] rd_val;

        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
        ram_on = 1'b1; ram_data = 8'h96;
        #1;
        tick();
        chk("rst_state",   32'(state),   32'd5);
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_rd_en",   32'(rd_en),   32'd0);
        chk("rst_miso",    32'(miso),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wdata",   32'(wdata),   32'd0);
        rst = 1'b0;
        idle_tick();
        chk("idle_state", 32'(state), 32'd0);

        // Test 1: set write address then single write
        send_bit(1'b0); send_bit(1'b0); send_word(8'h3C);
        chk("t1_wr_addr", 32'(wr_addr), 32'h3C);
        chk("t1_done",    32'(state),   32'd5);
        idle_tick();
        base = wr_cnt;
        send_bit(1'b0); send_bit(1'b1);
        send_word(8'hA5);
        chk("t1_wr_en_c10", 32'(wr_en),   32'd1);
        chk("t1_wdata",     32'(wdata),   32'hA5);
        chk("t1_wr_addr_s", 32'(wr_addr), 32'h3C);
        idle_tick();
        chk("t1_wr_en_c11", 32'(wr_en),        32'd0);
        chk("t1_pulses",    32'(wr_cnt - base), 32'd1);
        chk("t1_abort_idle", 32'(state),       32'd0);

        // Test 2: burst write with address wrap
        send_bit(1'b0); send_bit(1'b0); send_word(8'hFE);
        idle_tick();
        base = wr_cnt;
        send_bit(1'b0); send_bit(1'b1);
        send_word(8'h11); send_word(8'h22); send_word(8'h33);
        idle_tick();
        idle_tick();
        chk("t2_pulses", 32'(wr_cnt - base), 32'd3);
        if (wr_cnt - base == 3) begin
            chk("t2_a0", 32'(wr_addr_q[base]),     32'hFE);
            chk("t2_d0", 32'(wr_data_q[base]),     32'h11);
            chk("t2_a1", 32'(wr_addr_q[base + 1]), 32'hFF);
            chk("t2_d1", 32'(wr_data_q[base + 1]), 32'h22);
            chk("t2_a2", 32'(wr_addr_q[base + 2]), 32'h00);
            chk("t2_d2", 32'(wr_data_q[base + 2]), 32'h33);
        end
        chk("t2_wr_addr_after", 32'(wr_addr), 32'h01);

        // Test 3: set read address, then read one word
        send_bit(1'b1); send_bit(1'b0); send_word(8'h10);
        idle_tick();
        rd_base = rd_cnt;
        base = wr_cnt;
        rd_val = 8'h96;
        send_bit(1'b1); send_bit(1'b1);
        chk("t3_rd_en_c2",   32'(rd_en),   32'd1);
        chk("t3_rd_addr",    32'(rd_addr), 32'h10);
        chk("t3_state_wait", 32'(state),   32'd3);
        chk("t3_miso_c2",    32'(miso),    32'd0);
        send_bit(1'b1);
        chk("t3_rd_en_c3", 32'(rd_en), 32'd0);
        send_bit(1'b1);
        chk("t3_state_shift", 32'(state), 32'd4);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_miso_c%0d", i + 4), 32'(miso), 32'(rd_val[7 - i]));
            ss_n = (i == 7);
            mosi = 1'b1;
            tick();
        end
        chk("t3_done",     32'(state),          32'd5);
        chk("t3_miso_end", 32'(miso),           32'd0);
        chk("t3_rd_pulse", 32'(rd_cnt - rd_base), 32'd1);
        chk("t3_no_wr",    32'(wr_cnt - base),    32'd0);
        idle_tick();

        // Test 4: write frame aborted after 5 payload bits
        base = wr_cnt;
        send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        idle_tick();
        chk("t4_state_idle", 32'(state),        32'd0);
        chk("t4_wr_addr",    32'(wr_addr),      32'h01);
        idle_tick();
        chk("t4_no_wr",      32'(wr_cnt - base), 32'd0);

        // Test 5: read timeout
        ram_on = 1'b0;
        send_bit(1'b1); send_bit(1'b1);
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        chk("t5_err_c17",   32'(err),   32'd0);
        chk("t5_state_c17", 32'(state), 32'd3);
        send_bit(1'b0);
        chk("t5_err",   32'(err),   32'd1);
        chk("t5_state", 32'(state), 32'd5);
        chk("t5_miso",  32'(miso),  32'd0);
        idle_tick();
        chk("t5_err_sticky", 32'(err), 32'd1);
        ram_on = 1'b1;
        send_bit(1'b0);
        chk("t5_err_clr", 32'(err), 32'd0);
        send_bit(1'b0); send_word(8'h55);
        chk("t5_wr_addr", 32'(wr_addr), 32'h55);
        idle_tick();

        // Test 6: reset in the middle of a burst with SS_n held low
        send_bit(1'b0); send_bit(1'b1);
        send_word(8'h11);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1;
        send_bit(1'b1);
        rst = 1'b0;
        chk("t6_state",   32'(state),   32'd5);
        chk("t6_wr_en",   32'(wr_en),   32'd0);
        chk("t6_rd_en",   32'(rd_en),   32'd0);
        chk("t6_miso",    32'(miso),    32'd0);
        chk("t6_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_rd_addr", 32'(rd_addr), 32'd0);
        chk("t6_wdata",   32'(wdata),   32'd0);
        base = wr_cnt;
        rd_base = rd_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'(i % 2));
        chk("t6_hold_done", 32'(state),            32'd5);
        chk("t6_no_wr",     32'(wr_cnt - base),    32'd0);
        chk("t6_no_rd",     32'(rd_cnt - rd_base), 32'd0);
        idle_tick();
        send_bit(1'b0); send_bit(1'b0); send_word(8'h07);
        chk("t6_wr_addr_new", 32'(wr_addr), 32'h07);
        idle_tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
